// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants, access classification and status packing for the
// memory/IO responder.
package mem_io_responder_pkg;

  localparam int unsigned IO_SEL_HI = 17;
  localparam int unsigned IO_SEL_LO = 16;
  localparam logic [1:0]  IO_SEL_VAL = 2'b11;

  localparam logic [2:0]  IO_OFS_DATA = 3'd0;
  localparam logic [2:0]  IO_OFS_CTRL = 3'd4;

  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_TX_FULL     = 1;
  localparam int unsigned STAT_ERR         = 2;

  typedef enum logic [1:0] {
    ACC_RAM     = 2'd0,
    ACC_IO_DATA = 2'd1,
    ACC_IO_CTRL = 2'd2,
    ACC_IO_NONE = 2'd3
  } acc_e;

  function automatic acc_e acc_decode(input logic [1:0] sel, input logic [2:0] ofs);
    acc_e acc;
    acc = ACC_RAM;
    if (sel == IO_SEL_VAL) begin
      if (ofs == IO_OFS_DATA)      acc = ACC_IO_DATA;
      else if (ofs == IO_OFS_CTRL) acc = ACC_IO_CTRL;
      else                         acc = ACC_IO_NONE;
    end
    return acc;
  endfunction

  function automatic logic [7:0] status_byte(input logic err, input logic tx_full,
                                             input logic rx_nonempty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_ERR]         = err;
    s[STAT_TX_FULL]     = tx_full;
    s[STAT_RX_NONEMPTY] = rx_nonempty;
    return s;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a pop frees room for a same-cycle push
// when full, and a pop on empty is ignored.
module byte_fifo #(
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned PTR_W = DEPTH_LOG + 1;

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]       mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                   (wr_q[DEPTH_LOG-1:0] == rd_q[DEPTH_LOG-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head reads as zero when empty so the output is clean out of reset.
  assign dout_o = empty_o ? 8'h00 : mem_q[rd_q[DEPTH_LOG-1:0]];

  always_comb begin
    wr_d = wr_q + PTR_W'(do_push);
    rd_d = rd_q + PTR_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[DEPTH_LOG-1:0]] <= din_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the byte-serial memory bus: byte RAM plus an IO window with
// RX/TX FIFOs, a status byte and a sticky halt flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned FIFO_DEPTH_LOG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_push_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        halt_o
);

  localparam int unsigned RAM_BYTES = 1 << ADDR_W;

  logic [7:0]        ram_q [RAM_BYTES];
  logic [ADDR_W-1:0] ram_idx;
  acc_e              acc;
  logic              cpu_rd, cpu_wr;
  logic              unused_addr;

  logic [7:0] mem_din_q, mem_din_d;
  logic       halt_q, halt_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       tx_drop_q, tx_drop_d;

  logic       rx_pop, rx_empty, rx_full;
  logic [7:0] rx_dout;
  logic       tx_push, tx_pop, tx_empty, tx_full;

  assign acc         = acc_decode(mem_a[IO_SEL_HI:IO_SEL_LO], mem_a[2:0]);
  assign ram_idx     = mem_a[ADDR_W-1:0];
  assign cpu_rd      = rdy_in && !mem_wr;
  assign cpu_wr      = rdy_in && mem_wr;
  assign unused_addr = ^mem_a;

  assign rx_pop  = cpu_rd && (acc == ACC_IO_DATA);
  assign tx_push = cpu_wr && (acc == ACC_IO_DATA);
  assign tx_pop  = tx_ready_i && !tx_empty;

  assign mem_din    = mem_din_q;
  assign halt_o     = halt_q;
  assign tx_valid_o = !tx_empty;

  byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push_i),
    .pop_i   (rx_pop),
    .din_i   (rx_byte_i),
    .dout_o  (rx_dout),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (mem_dout),
    .dout_o  (tx_byte_o),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  // RAM contents are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (cpu_wr && (acc == ACC_RAM)) ram_q[ram_idx] <= mem_dout;
  end

  always_comb begin
    mem_din_d = mem_din_q;
    halt_d    = halt_q;
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;

    if (cpu_rd) begin
      unique case (acc)
        ACC_RAM:     mem_din_d = ram_q[ram_idx];
        ACC_IO_DATA: mem_din_d = rx_dout;
        ACC_IO_CTRL: mem_din_d = status_byte(tx_drop_q | rx_ovf_q, tx_full, !rx_empty);
        default:     mem_din_d = 8'h00;
      endcase
    end

    if (cpu_wr && (acc == ACC_IO_CTRL)) halt_d = 1'b1;

    // A full FIFO is never empty, so a same-cycle pop always makes room.
    if (rx_push_i && rx_full && !rx_pop)    rx_ovf_d  = 1'b1;
    if (tx_push && tx_full && !tx_ready_i)  tx_drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_din_q <= 8'h00;
      halt_q    <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      halt_q    <= halt_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target end of the byte-serial memory bus that mem_ctrl drives. mem_ctrl issues one address per cycle, with a write flag and an 8-bit write byte, and samples din one cycle later.
- This block answers that bus with a byte RAM and a memory-mapped IO window. The window holds a UART-style RX FIFO, a TX FIFO, a status register and a halt register.
- Sits at top level between the CPU core and the board / simulation harness.

Parameters:
- ADDR_W, 17, RAM address bits; RAM holds 2^ADDR_W bytes.
- FIFO_DEPTH_LOG, 3, log2 of RX and TX FIFO depth (depth 8).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; when 0, no access has any effect.
- mem_a  in  32  byte address from mem_ctrl.
- mem_wr  in  1  1 = write this cycle, 0 = read.
- mem_dout  in  8  write byte from mem_ctrl.
- mem_din  out  8  registered read byte to mem_ctrl.
- rx_byte_i  in  8  incoming UART byte.
- rx_push_i  in  1  strobe: push rx_byte_i into the RX FIFO.
- tx_byte_o  out  8  head of the TX FIFO.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  consumer accepts tx_byte_o this cycle (pop when tx_valid_o is also 1).
- halt_o  out  1  sticky simulation-halt flag.

Behaviour:
- Region decode:
  - IO when mem_a[17:16] == 2'b11; otherwise RAM.
  - RAM index = mem_a[ADDR_W-1:0], so the address wraps modulo 2^ADDR_W.
  - In IO, only mem_a[2:0] is decoded.
- Read latency: exactly 1 cycle. mem_din updates at the posedge where the address is presented and is valid for the whole next cycle. This matches the mem_ctrl read_sta 2..5 sampling.
- RAM read (mem_wr = 0, rdy_in = 1): mem_din <= ram[idx].
- RAM write (mem_wr = 1, rdy_in = 1):
  - ram[idx] <= mem_dout.
  - mem_din holds its previous value.
  - A read of the same index in the next cycle returns the new byte.
- IO map:
  - Offset 0, read: mem_din <= RX head and the RX FIFO pops. If RX is empty, mem_din <= 8'h00 and nothing pops.
  - Offset 0, write: push mem_dout into TX. If TX is full, the byte is dropped and tx_drop is set.
  - Offset 4, read: mem_din <= {5'b0, tx_drop|rx_ovf, tx_full, rx_nonempty}.
  - Offset 4, write: halt_o <= 1 (sticky until reset).
  - Other offsets: reads return 8'h00, writes are ignored.
- RX FIFO:
  - A push while full drops the byte and sets sticky rx_ovf.
  - Push on a full FIFO with a simultaneous CPU pop: both happen and the byte is accepted.
  - Pop on an empty FIFO with a simultaneous push: no pop, no bypass; mem_din = 8'h00 and the byte is stored.
  - rx_push_i is honoured regardless of rdy_in. Only CPU-side accesses are gated by rdy_in.
- TX FIFO:
  - A pop (tx_valid_o & tx_ready_i) and a CPU push may occur in the same cycle.
  - A push into a full FIFO with a simultaneous pop is accepted.
  - The pop side is independent of rdy_in.
  - tx_valid_o and tx_byte_o are combinational from the FIFO state and head entry.
- rdy_in = 0: no RAM write, no IO side effect, mem_din holds.
- Reset (async, any time, including mid-burst):
  - mem_din = 0, halt_o = 0, tx_valid_o = 0, tx_byte_o = 0.
  - Both FIFOs empty; rx_ovf = 0, tx_drop = 0.
  - RAM contents are not reset; they are loaded by $readmemh in simulation.
- FIFO pointers are FIFO_DEPTH_LOG+1 bits wide. Full = MSBs differ and the low bits are equal.

Decomposition:
- Shared defines header gets: IO_SEL bits (17:16), IO_OFS_DATA = 3'd0, IO_OFS_CTRL = 3'd4, and the status bit positions.
- One sub-module, byte_fifo, parameterised by depth log:
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full.
  - Simultaneous push/pop rules as above.
  - Instantiated twice, once for RX and once for TX.

Test Plan:
- RAM write/read: write 8'hA5 to 0x00010, then read 0x00010. mem_din = 8'hA5 one cycle after the read address. 4-byte burst read at 0x10..0x13 returns bytes in order, one per cycle.
- Wrap: write 8'h3C to 0x20005 (ADDR_W = 17), then read 0x00005 -> 8'h3C.
- RX path:
  - Pulse rx_push_i with 8'h41 and 8'h42; read 0x30000 twice -> 8'h41, 8'h42; a third read -> 8'h00.
  - Status read at 0x30004 -> 8'h00 afterwards.
  - Push 9 bytes -> status bit2 = 1; the 9th byte is lost.
- TX path:
  - Hold tx_ready_i = 0; write 8 bytes to 0x30000 -> status bit1 = 1. A 9th write is dropped and bit2 = 1.
  - Raise tx_ready_i -> bytes 1..8 appear in order, then tx_valid_o = 0.
- Gating/halt:
  - With rdy_in = 0, a write to RAM and to 0x30004 has no effect: RAM is unchanged and halt_o = 0.
  - With rdy_in = 1, a write to 0x30004 -> halt_o = 1 the next cycle.
- Async reset: assert rst between edges while the TX FIFO is non-empty -> tx_valid_o and mem_din go to 0 immediately; a RAM byte written before the reset reads back unchanged.
